fir_stage_sched: RTL and testbench
==================================

FIR_STAGE_SCHED -- requirements
Module: fir_stage_sched

Interface
REQ-001 Parameter DATA_W, default 16, sample width to the FIR stage.
REQ-002 Parameter OUT_W, default 34, FIR result width.
REQ-003 Parameter DEPTH, default 8, input FIFO depth (power of 2).
REQ-004 Parameter DIV_RST, default 100, strobe interval after reset (130 MHz / 100 = 1.3 MHz).
REQ-005 Clocking: one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  system clock (130 MHz).
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 in_data  in  DATA_W  signed sample from the previous stage.
REQ-009 in_valid  in  1  in_data is valid.
REQ-010 in_ready  out  1  FIFO can accept a sample.
REQ-011 enable  in  1  run the strobe schedule.
REQ-012 div_cfg  in  8  strobe interval in clk cycles.
REQ-013 clear  in  1  clears the sticky flags.
REQ-014 fir_sink_data  out  DATA_W  sample to the FIR.
REQ-015 fir_sink_valid  out  1  single-cycle sample strobe.
REQ-016 fir_sink_error  out  2  tied to 0.
REQ-017 fir_source_data  in  OUT_W  FIR result.
REQ-018 fir_source_valid  in  1  FIR result valid.
REQ-019 fir_source_error  in  2  FIR error code.
REQ-020 out_data  out  OUT_W  registered FIR result.
REQ-021 out_valid  out  1  one-cycle pulse, out_data is new.
REQ-022 fifo_level  out  $clog2(DEPTH)+1  FIFO occupancy.
REQ-023 underflow  out  1  sticky; a tick found the FIFO empty.
REQ-024 err_sticky  out  1  sticky; the FIR reported an error.

Function
REQ-025 FIFO write when in_valid && in_ready; in_ready = (fifo_level < DEPTH); a full FIFO refuses writes even when a pop occurs in the same cycle.
REQ-026 FSM states: IDLE, PRIME, RUN.
  - IDLE -> PRIME when enable=1.
  - PRIME -> RUN when fifo_level >= 2.
  - PRIME/RUN -> IDLE when enable=0, effective the next cycle.
REQ-027 Tick counter:
  - loaded with eff_div-1 on entry to RUN and on every tick;
  - counts down once per clk in RUN;
  - tick = count==0.
  - eff_div = max(div_cfg,2), sampled only at load.
REQ-028 At a tick with the FIFO non-empty:
  - pop the head;
  - drive fir_sink_data = head and fir_sink_valid=1 for exactly 1 cycle, on the cycle after the tick.
REQ-029 At a tick with the FIFO empty: no strobe, set underflow, stay in RUN, reload the counter.
REQ-030 fir_sink_data holds its last value while fir_sink_valid=0.
REQ-031 First strobe occurs eff_div cycles after the RUN entry cycle.
REQ-032 Result capture:
  - fir_source_valid=1 -> out_data <= fir_source_data and out_valid=1 the next cycle;
  - results are captured in every FSM state.
REQ-033 fir_source_valid=1 with fir_source_error != 0 sets err_sticky; the data is still forwarded.
REQ-034 clear=1 zeroes both sticky flags; if a set and a clear occur in the same cycle, the set wins.
REQ-035 Leaving RUN drops any pending tick; FIFO contents are retained.

Reset
REQ-036 reset_n=0 asynchronously forces:
  - FSM=IDLE, counter=0, FIFO empty (fifo_level=0, in_ready=1);
  - fir_sink_data=0, fir_sink_valid=0;
  - out_data=0, out_valid=0;
  - underflow=0, err_sticky=0.
REQ-037 Reset asserted mid-strobe truncates the strobe immediately; no sample is lost silently, because FIFO contents are discarded by definition.

Structure
REQ-038 Shared package fir_sched_pkg holds the FSM state typedef, DIV_MIN=2 and PRIME_LVL=2.
REQ-039 The FIFO is sub-module fir_sched_fifo (parameters DATA_W, DEPTH; push, pop, level); the FSM, counter and capture stay in the top.

Verification
REQ-040 Push 4 samples 0x0001..0x0004, div_cfg=100, enable=1 -> strobes 100 clk apart carrying 1,2,3,4, each exactly 1 cycle wide.
REQ-041 div_cfg=0 or 1 -> strobe spacing is 2 cycles.
REQ-042 Fill 8 samples with no enable -> in_ready=0, fifo_level=8; a 9th in_valid is dropped; enable then pops all 8 in order.
REQ-043 RUN with 2 samples, no further pushes -> 2 strobes, then underflow=1 at the 3rd tick; clear in the same cycle as a new underflow -> underflow stays 1.
REQ-044 fir_source_valid pulse with data 0x2_0000_0001 and error 2'b01 -> out_data=0x2_0000_0001 and out_valid one cycle later, err_sticky=1.
REQ-045 reset_n low for 1 cycle during a strobe -> fir_sink_valid=0 immediately, FSM=IDLE, fifo_level=0.

Source files
------------

// File: rtl/fir_sched_pkg.sv
// Shared types and constants for the FIR stage sample scheduler.
// No logic; latency and backpressure belong to the modules that import it.
package fir_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int DIV_MIN   = 2;
  localparam int PRIME_LVL = 2;

  // Intervals below DIV_MIN would make the counter reload collide with the tick.
  function automatic logic [7:0] eff_div(input logic [7:0] div);
    return (div < 8'(DIV_MIN)) ? 8'(DIV_MIN) : div;
  endfunction

endpackage

// File: rtl/fir_sched_fifo.sv
// Sample FIFO ahead of the FIR: head is visible combinationally, a pop advances it next cycle.
// Backpressure: ready drops at DEPTH entries; a full FIFO refuses a push even alongside a pop.
module fir_sched_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic                     ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign ready   = (level < (AW+1)'(DEPTH));
  assign do_push = push && ready;
  assign do_pop  = pop && (level != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: emptiness is tracked by level alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fir_stage_sched.sv
// Paces buffered samples into a FIR core at div_cfg-cycle ticks and registers its results.
// Strobe lands one cycle after its tick, result one cycle after fir_source_valid; in_ready is FIFO space.
module fir_stage_sched
  import fir_sched_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int OUT_W   = 34,
  parameter int DEPTH   = 8,
  parameter int DIV_RST = 100
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     enable,
  input  logic [7:0]               div_cfg,
  input  logic                     clear,
  output logic [DATA_W-1:0]        fir_sink_data,
  output logic                     fir_sink_valid,
  output logic [1:0]               fir_sink_error,
  input  logic [OUT_W-1:0]         fir_source_data,
  input  logic                     fir_source_valid,
  input  logic [1:0]               fir_source_error,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     underflow,
  output logic                     err_sticky
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  // The nominal reset-time interval must be reachable through the 8-bit div_cfg.
  if (DIV_RST < DIV_MIN || DIV_RST > 255) begin : g_bad_div_rst
    $error("DIV_RST out of range");
  end

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        count;
  logic [DATA_W-1:0] head;
  logic              enter_run;
  logic              tick;
  logic              fifo_empty;
  logic              pop;

  fir_sched_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop),
    .head      (head),
    .ready     (in_ready),
    .level     (fifo_level)
  );

  assign fifo_empty = (fifo_level == '0);
  assign enter_run  = (state == PRIME) && enable && (fifo_level >= LVL_W'(PRIME_LVL));
  // A tick in the cycle enable falls is dropped along with the RUN state.
  assign tick       = (state == RUN) && enable && (count == '0);
  assign pop        = tick && !fifo_empty;

  assign fir_sink_error = 2'b00;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = PRIME;
      PRIME:   if (!enable) state_nxt = IDLE;
               else if (fifo_level >= LVL_W'(PRIME_LVL)) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (enter_run || tick)
        count <= eff_div(div_cfg) - 8'd1;
      else if (state == RUN && count != '0)
        count <= count - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fir_sink_data  <= '0;
      fir_sink_valid <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      fir_sink_valid <= pop;
      if (pop) fir_sink_data <= head;
      if (tick && fifo_empty) underflow <= 1'b1;
      else if (clear)         underflow <= 1'b0;
    end
  end

  // Results are accepted whatever the scheduler state; errors never block forwarding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      out_valid <= fir_source_valid;
      if (fir_source_valid) out_data <= fir_source_data;
      if (fir_source_valid && fir_source_error != 2'b00) err_sticky <= 1'b1;
      else if (clear)                                   err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_stage_sched.sv
// Scoreboarded bench for fir_stage_sched: directed stimulus queues expected strobes and results,
// a negedge monitor pops and compares them against data, arrival cycle and pulse width.
module tb_fir_stage_sched;
  import fir_sched_pkg::*;

  localparam int DATA_W = 16;
  localparam int OUT_W  = 34;
  localparam int DEPTH  = 8;
  localparam int LVL_W  = 4;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } sink_exp_t;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             err;
    int               cyc;
  } out_exp_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              enable;
  logic [7:0]        div_cfg;
  logic              clear;
  logic [DATA_W-1:0] fir_sink_data;
  logic              fir_sink_valid;
  logic [1:0]        fir_sink_error;
  logic [OUT_W-1:0]  fir_source_data;
  logic              fir_source_valid;
  logic [1:0]        fir_source_error;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic [LVL_W-1:0]  fifo_level;
  logic              underflow;
  logic              err_sticky;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_sink_cyc = 0;
  logic prev_sink_vld = 1'b0;
  logic prev_out_vld  = 1'b0;

  sink_exp_t sink_q[$];
  out_exp_t  out_q[$];

  fir_stage_sched #(
    .DATA_W  (DATA_W),
    .OUT_W   (OUT_W),
    .DEPTH   (DEPTH),
    .DIV_RST (100)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .enable           (enable),
    .div_cfg          (div_cfg),
    .clear            (clear),
    .fir_sink_data    (fir_sink_data),
    .fir_sink_valid   (fir_sink_valid),
    .fir_sink_error   (fir_sink_error),
    .fir_source_data  (fir_source_data),
    .fir_source_valid (fir_source_valid),
    .fir_source_error (fir_source_error),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .fifo_level       (fifo_level),
    .underflow        (underflow),
    .err_sticky       (err_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_samples(input logic [DATA_W-1:0] base, input int inc, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(int'(base) + i * inc);
      step(1);
    end
    in_valid = 1'b0;
  endtask

  // Called at the point enable is raised; arrival cycles are relative to now.
  task automatic expect_strobes(input logic [DATA_W-1:0] base, input int inc, input int n,
                                input int first, input int gap);
    sink_exp_t e;
    for (int k = 0; k < n; k++) begin
      e.data = DATA_W'(int'(base) + k * inc);
      e.cyc  = cyc + first + k * gap;
      sink_q.push_back(e);
    end
  endtask

  task automatic wait_sink_drain(input string name, input int budget);
    int t = 0;
    while (sink_q.size() != 0 && t < budget) begin
      step(1);
      t++;
    end
    check(name, 64'(sink_q.size()), 64'd0);
  endtask

  task automatic wait_out_drain(input string name, input int budget);
    int t = 0;
    while (out_q.size() != 0 && t < budget) begin
      step(1);
      t++;
    end
    check(name, 64'(out_q.size()), 64'd0);
  endtask

  task automatic fir_result(input logic [OUT_W-1:0] d, input logic [1:0] er, input logic clr,
                            input logic exp_err);
    out_exp_t e;
    e.data = d;
    e.err  = exp_err;
    e.cyc  = cyc + 1;
    out_q.push_back(e);
    fir_source_valid = 1'b1;
    fir_source_data  = d;
    fir_source_error = er;
    clear            = clr;
    step(1);
    fir_source_valid = 1'b0;
    fir_source_data  = '0;
    fir_source_error = 2'b00;
    clear            = 1'b0;
  endtask

  always @(negedge clk) begin
    sink_exp_t se;
    out_exp_t  oe;
    if (fir_sink_valid) begin
      if (sink_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sink_unexpected: strobe data 0x%0h at cycle %0d, none expected", fir_sink_data, cyc);
      end else begin
        se = sink_q.pop_front();
        check("sink_data", 64'(fir_sink_data), 64'(se.data));
        check("sink_cycle", 64'(cyc), 64'(se.cyc));
      end
      check("sink_width", 64'(prev_sink_vld), 64'd0);
      last_sink_cyc = cyc;
    end
    prev_sink_vld = fir_sink_valid;

    if (out_valid) begin
      if (out_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_unexpected: out_data 0x%0h at cycle %0d, none expected", out_data, cyc);
      end else begin
        oe = out_q.pop_front();
        check("out_data", 64'(out_data), 64'(oe.data));
        check("out_err_sticky", 64'(err_sticky), 64'(oe.err));
        check("out_cycle", 64'(cyc), 64'(oe.cyc));
      end
      check("out_width", 64'(prev_out_vld), 64'd0);
    end
    prev_out_vld = out_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset_n          = 1'b0;
    in_data          = '0;
    in_valid         = 1'b0;
    enable           = 1'b0;
    div_cfg          = 8'd100;
    clear            = 1'b0;
    fir_source_data  = '0;
    fir_source_valid = 1'b0;
    fir_source_error = 2'b00;
    step(2);

    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_sink_valid", 64'(fir_sink_valid), 64'd0);
    check("rst_sink_data", 64'(fir_sink_data), 64'd0);
    check("rst_sink_error", 64'(fir_sink_error), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_underflow", 64'(underflow), 64'd0);
    check("rst_err_sticky", 64'(err_sticky), 64'd0);
    check("rst_state", 64'(dut.state), 64'(IDLE));
    reset_n = 1'b1;
    step(1);

    // Four samples at interval 100: IDLE->PRIME->RUN takes two cycles, first strobe 100 later.
    push_samples(16'h0001, 1, 4);
    step(1);
    check("t1_level", 64'(fifo_level), 64'd4);
    enable = 1'b1;
    expect_strobes(16'h0001, 1, 4, 102, 100);
    wait_sink_drain("t1_drain", 500);
    enable = 1'b0;
    step(3);
    check("t1_hold_valid", 64'(fir_sink_valid), 64'd0);
    check("t1_hold_data", 64'(fir_sink_data), 64'd4);
    check("t1_level_end", 64'(fifo_level), 64'd0);
    check("t1_no_underflow", 64'(underflow), 64'd0);

    // Intervals of 0 and 1 are raised to 2.
    div_cfg = 8'd0;
    push_samples(16'h0011, 16'h11, 3);
    enable = 1'b1;
    expect_strobes(16'h0011, 16'h11, 3, 4, 2);
    wait_sink_drain("t2_div0_drain", 50);
    enable = 1'b0;
    step(3);
    div_cfg = 8'd1;
    push_samples(16'h005a, 1, 2);
    enable = 1'b1;
    expect_strobes(16'h005a, 1, 2, 4, 2);
    wait_sink_drain("t2_div1_drain", 50);
    enable = 1'b0;
    step(3);

    // Fill to DEPTH with no enable; the ninth offer is refused.
    div_cfg  = 8'd2;
    in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_data = DATA_W'(16'h0100 + i);
      if (i == 8) begin
        check("t3_full_ready", 64'(in_ready), 64'd0);
        check("t3_full_level", 64'(fifo_level), 64'd8);
      end
      step(1);
    end
    in_valid = 1'b0;
    check("t3_level_after_drop", 64'(fifo_level), 64'd8);
    enable = 1'b1;
    expect_strobes(16'h0100, 1, 8, 4, 2);
    wait_sink_drain("t3_drain", 100);
    enable = 1'b0;
    step(3);
    check("t3_level_end", 64'(fifo_level), 64'd0);

    // Two samples, then the third tick finds the FIFO empty.
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("t4_underflow_cleared", 64'(underflow), 64'd0);
    div_cfg = 8'd5;
    push_samples(16'h0055, 16'h11, 2);
    enable = 1'b1;
    expect_strobes(16'h0055, 16'h11, 2, 7, 5);
    wait_sink_drain("t4_drain", 50);
    t = 0;
    while (!underflow && t < 20) begin
      step(1);
      t++;
    end
    check("t4_underflow_rise", 64'(underflow), 64'd1);
    check("t4_underflow_delay", 64'(cyc - last_sink_cyc), 64'd5);
    check("t4_still_run", 64'(dut.state), 64'(RUN));
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("t4_clear", 64'(underflow), 64'd0);
    step(3);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("t4_set_wins", 64'(underflow), 64'd1);
    enable = 1'b0;
    clear  = 1'b1;
    step(1);
    clear = 1'b0;
    check("t4_final_clear", 64'(underflow), 64'd0);

    // Result capture and the error flag, including set-versus-clear.
    fir_result(34'h2_0000_0001, 2'b01, 1'b0, 1'b1);
    wait_out_drain("t5_first_drain", 10);
    check("t5_out_hold", 64'(out_data), 64'h2_0000_0001);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("t5_err_clear", 64'(err_sticky), 64'd0);
    fir_result(34'h1_2345_6789, 2'b00, 1'b0, 1'b0);
    wait_out_drain("t5_clean_drain", 10);
    fir_result(34'h3_ffff_fffe, 2'b10, 1'b1, 1'b1);
    wait_out_drain("t5_setwins_drain", 10);
    check("t5_err_hold", 64'(err_sticky), 64'd1);

    // Reset pulse in the middle of a strobe.
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    div_cfg = 8'd2;
    push_samples(16'h0077, 1, 3);
    enable = 1'b1;
    expect_strobes(16'h0077, 1, 1, 4, 2);
    t = 0;
    while (!fir_sink_valid && t < 20) begin
      step(1);
      t++;
    end
    check("t6_strobe_seen", 64'(fir_sink_valid), 64'd1);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    check("t6_valid_drop", 64'(fir_sink_valid), 64'd0);
    check("t6_sink_data", 64'(fir_sink_data), 64'd0);
    check("t6_state", 64'(dut.state), 64'(IDLE));
    check("t6_level", 64'(fifo_level), 64'd0);
    check("t6_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(10);
    check("t6_level_after", 64'(fifo_level), 64'd0);
    check("t6_quiet", 64'(fir_sink_valid), 64'd0);

    check("end_sink_queue", 64'(sink_q.size()), 64'd0);
    check("end_out_queue", 64'(out_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
